// File: rtl/push_button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: button indices,
// channel FSM encoding, counter width and the per-channel pulse bundle.
package push_button_conditioner_pkg;

    localparam int NUM_BTN = 5;
    localparam int CNT_W   = 16;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_M = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_DB_RELEASE = 2'd3
    } btn_state_e;

    // One-cycle event pulses produced by a channel ("release" is a reserved word).
    typedef struct packed {
        logic press;
        logic rel;
        logic step;
    } btn_evt_t;

endpackage

// File: rtl/push_button_conditioner_if.sv
// Button bundle: raw inputs in, conditioned level and pulses out.
interface push_button_conditioner_if;
    import push_button_conditioner_pkg::*;

    logic [NUM_BTN-1:0] push_raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] released;
    logic [NUM_BTN-1:0] step;
    logic               any_press;

    // Source of the raw buttons and consumer of the conditioned signals.
    modport master (
        output push_raw,
        input  level, press, released, step, any_press
    );

    // The conditioner itself.
    modport slave (
        input  push_raw,
        output level, press, released, step, any_press
    );
endinterface

// File: rtl/push_button_channel.sv
// One button: 2-flop synchronizer, debounce FSM, hold/auto-repeat counter.
module push_button_channel
    import push_button_conditioner_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] REPEAT_DELAY    = 16'd50000,
    parameter logic [15:0] REPEAT_PERIOD   = 16'd12500
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     raw,
    output logic     level,
    output btn_evt_t evt
);

    localparam cnt_t           DB_LAST  = cnt_t'(DEBOUNCE_CYCLES - 16'd1);
    localparam logic [CNT_W:0] RPT_WRAP = {1'b0, REPEAT_DELAY} + {1'b0, REPEAT_PERIOD};

    logic [1:0]     sync_pipe;
    logic           btn;
    btn_state_e     state;
    cnt_t           db_cnt;
    cnt_t           hold_cnt;
    logic [CNT_W:0] hold_inc;
    logic           hit_first;
    logic           hit_wrap;
    logic           rpt_hit;
    cnt_t           hold_next;

    assign btn = sync_pipe[1];

    // Metastability guard: raw is asynchronous to clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_pipe <= '0;
        else         sync_pipe <= {sync_pipe[0], raw};
    end

    // Hold advance: first repeat at REPEAT_DELAY, then the counter folds back
    // to REPEAT_DELAY every REPEAT_PERIOD so it never overflows.
    always_comb begin
        hold_inc  = {1'b0, hold_cnt} + (CNT_W+1)'(1);
        hit_first = (hold_inc == {1'b0, REPEAT_DELAY});
        hit_wrap  = (hold_inc == RPT_WRAP);
        rpt_hit   = hit_first | hit_wrap;
        hold_next = hit_wrap ? REPEAT_DELAY : hold_inc[CNT_W-1:0];
    end

    // Debounce/hold FSM with registered level and pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            db_cnt   <= '0;
            hold_cnt <= '0;
            level    <= 1'b0;
            evt      <= '0;
        end else begin
            evt <= '0;
            case (state)
                ST_IDLE: begin
                    if (btn) begin
                        state  <= ST_DB_PRESS;
                        db_cnt <= '0;
                    end
                end
                ST_DB_PRESS: begin
                    if (!btn) begin
                        state <= ST_IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= ST_PRESSED;
                        evt.press <= 1'b1;
                        evt.step  <= 1'b1;
                        level     <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        db_cnt <= db_cnt + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!btn) begin
                        // hold_cnt is left untouched: frozen while release debounces
                        state  <= ST_DB_RELEASE;
                        db_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_next;
                        evt.step <= rpt_hit;
                    end
                end
                ST_DB_RELEASE: begin
                    if (btn) begin
                        // glitch: resume the hold where it stopped, no new press
                        state    <= ST_PRESSED;
                        hold_cnt <= hold_next;
                        evt.step <= rpt_hit;
                    end else if (db_cnt == DB_LAST) begin
                        state   <= ST_IDLE;
                        evt.rel <= 1'b1;
                        level   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/push_button_conditioner.sv
// Five independent debounced/auto-repeating button channels.
module push_button_conditioner
    import push_button_conditioner_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] REPEAT_DELAY    = 16'd50000,
    parameter logic [15:0] REPEAT_PERIOD   = 16'd12500
) (
    input  logic                      clk,
    input  logic                      resetn,
    push_button_conditioner_if.slave  bus
);

    btn_evt_t [NUM_BTN-1:0] evt;
    logic     [NUM_BTN-1:0] level;
    logic     [NUM_BTN-1:0] press;
    logic     [NUM_BTN-1:0] rel;
    logic     [NUM_BTN-1:0] step;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        push_button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk    (clk),
            .resetn (resetn),
            .raw    (bus.push_raw[i]),
            .level  (level[i]),
            .evt    (evt[i])
        );
    end

    // Split the per-channel pulse bundles into per-signal vectors.
    always_comb begin
        press = '0;
        rel   = '0;
        step  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            press[i] = evt[i].press;
            rel[i]   = evt[i].rel;
            step[i]  = evt[i].step;
        end
    end

    assign bus.level     = level;
    assign bus.press     = press;
    assign bus.released  = rel;
    assign bus.step      = step;
    assign bus.any_press = |press;

endmodule

// File: tb/tb_push_button_conditioner.sv
// Bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3. Edge k of a
// scenario is the k-th rising edge after raw is first driven (edge 0 samples it).
module tb_push_button_conditioner;
    import push_button_conditioner_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    push_button_conditioner_if bif();

    push_button_conditioner #(
        .DEBOUNCE_CYCLES (16'd4),
        .REPEAT_DELAY    (16'd10),
        .REPEAT_PERIOD   (16'd3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif.slave)
    );

    typedef struct {
        string      name;
        logic [4:0] mask;
        int         hi_len;   // raw = mask for k < hi_len ...
        int         gap_at;   // ... except gap_len cycles starting at gap_at
        int         gap_len;
        int         len;
        int         press_at;
        int         rel_at;
        int         step_at[8];
    } vec_t;

    // Expected {level, press, release, step, any_press}
    typedef struct {
        string       tag;
        int          k;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[5];

    function automatic logic [4:0] bit_of(input int idx);
        logic [4:0] m;
        m = 5'd1 << idx;
        return m;
    endfunction

    function automatic vec_t mk(input string n, input logic [4:0] m, input int hi, input int ga,
                                input int gl, input int len, input int pa, input int ra,
                                input int s0 = -1, input int s1 = -1, input int s2 = -1,
                                input int s3 = -1, input int s4 = -1, input int s5 = -1,
                                input int s6 = -1);
        vec_t v;
        v.name = n; v.mask = m; v.hi_len = hi; v.gap_at = ga; v.gap_len = gl;
        v.len = len; v.press_at = pa; v.rel_at = ra;
        v.step_at[0] = s0; v.step_at[1] = s1; v.step_at[2] = s2; v.step_at[3] = s3;
        v.step_at[4] = s4; v.step_at[5] = s5; v.step_at[6] = s6; v.step_at[7] = -1;
        return v;
    endfunction

    function automatic logic [20:0] outs();
        return {bif.level, bif.press, bif.released, bif.step, bif.any_press};
    endfunction

    task automatic compare(input string tag, input int k, input logic [20:0] exp_v);
        logic [20:0] got;
        got = outs();
        tests++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL %s k=%0d got lvl/prs/rel/stp/any=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                     tag, k, got[20:16], got[15:11], got[10:6], got[5:1], got[0],
                     exp_v[20:16], exp_v[15:11], exp_v[10:6], exp_v[5:1], exp_v[0]);
        end
    endtask

    // Drive raw for the next edge, queue what that edge must produce, check it.
    task automatic cycle(input logic [4:0] raw, input logic [20:0] ev, input string tag, input int k);
        exp_t e;
        bif.push_raw = raw;
        e.tag = tag; e.k = k; e.v = ev;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(e.tag, e.k, e.v);
    endtask

    task automatic run_vec(input vec_t v);
        logic [4:0] lvl, raw, p, r, s;
        lvl = '0;
        for (int k = 0; k < v.len; k++) begin
            raw = (k < v.hi_len && !(k >= v.gap_at && k < v.gap_at + v.gap_len)) ? v.mask : 5'd0;
            p   = (k == v.press_at) ? v.mask : 5'd0;
            r   = (k == v.rel_at)   ? v.mask : 5'd0;
            s   = '0;
            for (int j = 0; j < 8; j++) if (v.step_at[j] == k) s = v.mask;
            lvl = (lvl | p) & ~r;
            cycle(raw, {lvl, p, r, s, |p}, v.name, k);
        end
    endtask

    initial begin
        logic [4:0] m, lvl, p, s, r;
        bif.push_raw = '0;

        // Steps listed past the raw window are real: the FSM sees raw 2 edges late.
        vecs[0] = mk("clean",  bit_of(BTN_U), 30, 0, 0, 40, 6, 36, 6, 16, 19, 22, 25, 28, 31);
        vecs[1] = mk("bounce", bit_of(BTN_M), 20, 2, 1, 30, 9, 26, 9, 19);
        vecs[2] = mk("glitch", bit_of(BTN_U), 25, 9, 2, 35, 6, 31, 6, 18, 21, 24);
        vecs[3] = mk("simul",  bit_of(BTN_L) | bit_of(BTN_R), 8, 0, 0, 18, 6, 14, 6);
        vecs[4] = mk("short",  bit_of(BTN_D), 3, 0, 0, 10, -1, -1);

        // Reset state, then a couple of idle cycles out of reset.
        for (int k = 0; k < 3; k++) cycle('0, '0, "reset", k);
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) cycle('0, '0, "idle", k);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset during a hold: no release, then a fresh press after reset.
        m = bit_of(BTN_D);
        lvl = '0;
        for (int k = 0; k <= 12; k++) begin
            p = (k == 6) ? m : 5'd0;
            lvl |= p;
            cycle(m, {lvl, p, 5'd0, p, |p}, "hold_pre", k);
        end
        resetn = 1'b0;
        #1;
        compare("rst_async", 12, '0);
        for (int k = 0; k < 3; k++) cycle(m, '0, "in_reset", k);
        resetn = 1'b1;
        lvl = '0;
        for (int k = 0; k <= 20; k++) begin
            p = (k == 6) ? m : 5'd0;
            r = (k == 16) ? m : 5'd0;
            s = p;
            lvl = (lvl | p) & ~r;
            cycle((k < 10) ? m : 5'd0, {lvl, p, r, s, |p}, "hold_post", k);
        end

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
